wbck_ctrl: RTL and testbench

Writeback controller driving the register file write port (wbck_dest_wen/idx/dat).
- Arbitrates single-cycle ALU results against long-latency LSU/MDV results, then registers the winner into one write stage.
- Keeps a 32-entry pending-write scoreboard for long-latency destinations.
- Reports read-after-write hazards for the decode-stage source indices.

---
 rtl/wbck_ctrl.sv | 112 +++++++++++
 tb/tb_wbck_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wbck_ctrl.sv
// Writeback controller: LSU-over-ALU arbitration into a registered regfile write stage, 32-entry pending scoreboard, decode hazards; optional bypass under WBCK_BYPASS_EN.
// Latency: 1 cycle from transfer to wbck_dest_*; hazards and readies are combinational.
// Backpressure: LSU is always accepted, ALU stalls while LSU is valid, alloc stalls while its rd is pending.
module wbck_ctrl #(
  parameter int XLEN = 32,
  parameter int IDXW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_wbck_valid,
  output logic            alu_wbck_ready,
  input  logic [4:0]      alu_wbck_idx,
  input  logic [XLEN-1:0] alu_wbck_dat,
  input  logic            lsu_wbck_valid,
  output logic            lsu_wbck_ready,
  input  logic [4:0]      lsu_wbck_idx,
  input  logic [XLEN-1:0] lsu_wbck_dat,
  input  logic            oitf_alloc_valid,
  output logic            oitf_alloc_ready,
  input  logic [4:0]      oitf_alloc_idx,
  input  logic [4:0]      dec_src1_idx,
  input  logic [4:0]      dec_src2_idx,
  output logic            dec_src1_hazard,
  output logic            dec_src2_hazard,
  output logic            wbck_dest_wen,
  output logic [IDXW-1:0] wbck_dest_idx,
  output logic [XLEN-1:0] wbck_dest_dat
`ifdef WBCK_BYPASS_EN
  ,
  output logic [XLEN-1:0] dec_src1_byp_dat,
  output logic [XLEN-1:0] dec_src2_byp_dat,
  output logic            dec_src1_byp_sel,
  output logic            dec_src2_byp_sel
`endif
);

  logic [31:0]     pending;
  logic [31:0]     pending_nxt;
  logic            alu_xfer;
  logic            wb_xfer;
  logic            alloc_xfer;
  logic [4:0]      sel_idx;
  logic [XLEN-1:0] sel_dat;
  logic            src1_wr_match;
  logic            src2_wr_match;
  logic            src1_pend;
  logic            src2_pend;

  assign lsu_wbck_ready   = 1'b1;
  assign alu_wbck_ready   = ~lsu_wbck_valid;
  assign alu_xfer         = alu_wbck_valid & ~lsu_wbck_valid;
  assign wb_xfer          = lsu_wbck_valid | alu_xfer;
  assign oitf_alloc_ready = ~pending[oitf_alloc_idx];
  assign alloc_xfer       = oitf_alloc_valid & oitf_alloc_ready;

  assign sel_idx = lsu_wbck_valid ? lsu_wbck_idx : alu_wbck_idx;
  assign sel_dat = lsu_wbck_valid ? lsu_wbck_dat : alu_wbck_dat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbck_dest_wen <= 1'b0;
      wbck_dest_idx <= '0;
      wbck_dest_dat <= '0;
    end else if (wb_xfer) begin
      wbck_dest_wen <= (sel_idx != 5'd0);
      wbck_dest_idx <= {{(IDXW-5){1'b0}}, sel_idx};
      wbck_dest_dat <= sel_dat;
    end else begin
      wbck_dest_wen <= 1'b0;
    end
  end

  // Set is applied after clear so a same-edge alloc of the retiring rd stays pending.
  always_comb begin
    pending_nxt = pending;
    if (lsu_wbck_valid) begin
      pending_nxt[lsu_wbck_idx] = 1'b0;
    end
    if (alloc_xfer && (oitf_alloc_idx != 5'd0)) begin
      pending_nxt[oitf_alloc_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign src1_pend     = (dec_src1_idx != 5'd0) & pending[dec_src1_idx];
  assign src2_pend     = (dec_src2_idx != 5'd0) & pending[dec_src2_idx];
  assign src1_wr_match = (dec_src1_idx != 5'd0) & wbck_dest_wen &
                         (wbck_dest_idx == {{(IDXW-5){1'b0}}, dec_src1_idx});
  assign src2_wr_match = (dec_src2_idx != 5'd0) & wbck_dest_wen &
                         (wbck_dest_idx == {{(IDXW-5){1'b0}}, dec_src2_idx});

`ifdef WBCK_BYPASS_EN
  // The in-flight write is forwarded, so only scoreboard entries block decode.
  assign dec_src1_byp_dat = wbck_dest_dat;
  assign dec_src2_byp_dat = wbck_dest_dat;
  assign dec_src1_byp_sel = src1_wr_match;
  assign dec_src2_byp_sel = src2_wr_match;
  assign dec_src1_hazard  = src1_pend;
  assign dec_src2_hazard  = src2_pend;
`else
  assign dec_src1_hazard  = src1_pend | src1_wr_match;
  assign dec_src2_hazard  = src2_pend | src2_wr_match;
`endif

endmodule

// File: tb/tb_wbck_ctrl.sv
// Bench for wbck_ctrl: reference model plus scoreboard queue of expected write-stage values, table vectors and corner sequences.
module tb_wbck_ctrl;
  localparam int XLEN = 32;
  localparam int IDXW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_wbck_valid, alu_wbck_ready;
  logic [4:0]      alu_wbck_idx;
  logic [XLEN-1:0] alu_wbck_dat;
  logic            lsu_wbck_valid, lsu_wbck_ready;
  logic [4:0]      lsu_wbck_idx;
  logic [XLEN-1:0] lsu_wbck_dat;
  logic            oitf_alloc_valid, oitf_alloc_ready;
  logic [4:0]      oitf_alloc_idx;
  logic [4:0]      dec_src1_idx, dec_src2_idx;
  logic            dec_src1_hazard, dec_src2_hazard;
  logic            wbck_dest_wen;
  logic [IDXW-1:0] wbck_dest_idx;
  logic [XLEN-1:0] wbck_dest_dat;
`ifdef WBCK_BYPASS_EN
  logic [XLEN-1:0] dec_src1_byp_dat, dec_src2_byp_dat;
  logic            dec_src1_byp_sel, dec_src2_byp_sel;
`endif

  wbck_ctrl #(.XLEN(XLEN), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
    .alu_wbck_idx(alu_wbck_idx), .alu_wbck_dat(alu_wbck_dat),
    .lsu_wbck_valid(lsu_wbck_valid), .lsu_wbck_ready(lsu_wbck_ready),
    .lsu_wbck_idx(lsu_wbck_idx), .lsu_wbck_dat(lsu_wbck_dat),
    .oitf_alloc_valid(oitf_alloc_valid), .oitf_alloc_ready(oitf_alloc_ready),
    .oitf_alloc_idx(oitf_alloc_idx),
    .dec_src1_idx(dec_src1_idx), .dec_src2_idx(dec_src2_idx),
    .dec_src1_hazard(dec_src1_hazard), .dec_src2_hazard(dec_src2_hazard),
    .wbck_dest_wen(wbck_dest_wen), .wbck_dest_idx(wbck_dest_idx),
    .wbck_dest_dat(wbck_dest_dat)
`ifdef WBCK_BYPASS_EN
    ,
    .dec_src1_byp_dat(dec_src1_byp_dat), .dec_src2_byp_dat(dec_src2_byp_dat),
    .dec_src1_byp_sel(dec_src1_byp_sel), .dec_src2_byp_sel(dec_src2_byp_sel)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            wen;
    logic [IDXW-1:0] idx;
    logic [XLEN-1:0] dat;
  } wr_t;

  typedef struct {
    logic            av;
    logic [4:0]      ai;
    logic [XLEN-1:0] ad;
    logic            lv;
    logic [4:0]      li;
    logic [XLEN-1:0] ld;
    logic            exp_rdy;
    logic            exp_wen;
    logic [4:0]      exp_idx;
    logic [XLEN-1:0] exp_dat;
  } vec_t;

  wr_t             exp_q[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [31:0]     m_pend  = '0;
  logic            m_wen   = 1'b0;
  logic [IDXW-1:0] m_idx   = '0;
  logic [XLEN-1:0] m_dat   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic m_wr_match(input logic [4:0] s);
    return (s != 5'd0) && m_wen && (m_idx == {27'd0, s});
  endfunction

  function automatic logic m_haz(input logic [4:0] s);
`ifdef WBCK_BYPASS_EN
    return (s != 5'd0) && m_pend[s];
`else
    return (s != 5'd0) && (m_pend[s] || m_wr_match(s));
`endif
  endfunction

  // One clock: drive, check combinational outputs, predict and check the write stage.
  task automatic step(input logic av, input logic [4:0] ai, input logic [XLEN-1:0] ad,
                      input logic lv, input logic [4:0] li, input logic [XLEN-1:0] ld,
                      input logic ov, input logic [4:0] oi,
                      input logic [4:0] s1, input logic [4:0] s2);
    wr_t         e;
    logic [31:0] nxt;
    alu_wbck_valid = av; alu_wbck_idx = ai; alu_wbck_dat = ad;
    lsu_wbck_valid = lv; lsu_wbck_idx = li; lsu_wbck_dat = ld;
    oitf_alloc_valid = ov; oitf_alloc_idx = oi;
    dec_src1_idx = s1; dec_src2_idx = s2;
    #1;
    check("alu_ready", {63'd0, alu_wbck_ready}, {63'd0, !lv});
    check("lsu_ready", {63'd0, lsu_wbck_ready}, 64'd1);
    check("alloc_ready", {63'd0, oitf_alloc_ready}, {63'd0, !m_pend[oi]});
    check("src1_hazard", {63'd0, dec_src1_hazard}, {63'd0, m_haz(s1)});
    check("src2_hazard", {63'd0, dec_src2_hazard}, {63'd0, m_haz(s2)});
`ifdef WBCK_BYPASS_EN
    check("src1_byp_sel", {63'd0, dec_src1_byp_sel}, {63'd0, m_wr_match(s1)});
    check("src2_byp_sel", {63'd0, dec_src2_byp_sel}, {63'd0, m_wr_match(s2)});
    check("src1_byp_dat", {32'd0, dec_src1_byp_dat}, {32'd0, m_dat});
`endif
    nxt = m_pend;
    if (!rst_n) begin
      e.wen = 1'b0; e.idx = '0; e.dat = '0;
      nxt = '0;
    end else begin
      if (lv) begin
        e.wen = (li != 5'd0); e.idx = {27'd0, li}; e.dat = ld;
        nxt[li] = 1'b0;
      end else if (av) begin
        e.wen = (ai != 5'd0); e.idx = {27'd0, ai}; e.dat = ad;
      end else begin
        e.wen = 1'b0; e.idx = m_idx; e.dat = m_dat;
      end
      if (ov && !m_pend[oi] && oi != 5'd0) nxt[oi] = 1'b1;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("wen", {63'd0, wbck_dest_wen}, {63'd0, e.wen});
    check("idx", {32'd0, wbck_dest_idx}, {32'd0, e.idx});
    check("dat", {32'd0, wbck_dest_dat}, {32'd0, e.dat});
    m_wen = e.wen; m_idx = e.idx; m_dat = e.dat; m_pend = nxt;
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, s1, s2);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,   1'b0, 1'b1, 5'd4,  32'h22};
    vecs[1] = '{1'b1, 5'd3,  32'h11,       1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 5'd3,  32'h11};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 5'd3,  32'h11};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hA5A5, 1'b0, 1'b1, 5'd12, 32'hA5A5};
    vecs[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 5'd0,  32'hFFFFFFFF};
    vecs[5] = '{1'b1, 5'd2,  32'h99,       1'b1, 5'd0,  32'h1234, 1'b0, 1'b0, 5'd0,  32'h1234};
    vecs[6] = '{1'b1, 5'd31, 32'h80000001, 1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 5'd31, 32'h80000001};

    alu_wbck_valid = 0; alu_wbck_idx = 0; alu_wbck_dat = 0;
    lsu_wbck_valid = 0; lsu_wbck_idx = 0; lsu_wbck_dat = 0;
    oitf_alloc_valid = 0; oitf_alloc_idx = 0; dec_src1_idx = 0; dec_src2_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_wen", {63'd0, wbck_dest_wen}, 64'd0);
    check("rst_idx", {32'd0, wbck_dest_idx}, 64'd0);
    check("rst_dat", {32'd0, wbck_dest_dat}, 64'd0);
    check("rst_alloc_ready", {63'd0, oitf_alloc_ready}, 64'd1);

    // Single ALU write, then the write stage drops.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("alu5_ready", {63'd0, alu_wbck_ready}, 64'd1);
    check("alu5_wen", {63'd0, wbck_dest_wen}, 64'd1);
    check("alu5_idx", {32'd0, wbck_dest_idx}, 64'd5);
    check("alu5_dat", {32'd0, wbck_dest_dat}, 64'hDEADBEEF);
    idle(5'd0, 5'd0);
    check("alu5_wen_drop", {63'd0, wbck_dest_wen}, 64'd0);

    for (int i = 0; i < 7; i++) begin
      step(vecs[i].av, vecs[i].ai, vecs[i].ad, vecs[i].lv, vecs[i].li, vecs[i].ld,
           1'b0, 5'd0, 5'd0, 5'd0);
      check($sformatf("vec%0d_rdy", i), {63'd0, alu_wbck_ready}, {63'd0, vecs[i].exp_rdy});
      check($sformatf("vec%0d_wen", i), {63'd0, wbck_dest_wen}, {63'd0, vecs[i].exp_wen});
      check($sformatf("vec%0d_idx", i), {32'd0, wbck_dest_idx}, {59'd0, vecs[i].exp_idx});
      check($sformatf("vec%0d_dat", i), {32'd0, wbck_dest_dat}, {32'd0, vecs[i].exp_dat});
    end

    // Pending on idx 7, retire through LSU, hazard window of the write stage.
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
    check("haz7_set", {63'd0, dec_src1_hazard}, 64'd1);
    check("alloc7_again", {63'd0, oitf_alloc_ready}, 64'd0);
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
    step(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0);
`ifdef WBCK_BYPASS_EN
    check("haz7_wstage", {63'd0, dec_src1_hazard}, 64'd0);
    check("byp7_sel", {63'd0, dec_src1_byp_sel}, 64'd1);
`else
    check("haz7_wstage", {63'd0, dec_src1_hazard}, 64'd1);
`endif
    idle(5'd7, 5'd0);
    check("haz7_clear", {63'd0, dec_src1_hazard}, 64'd0);

    // Same-edge alloc and retire of idx 9: set wins.
    step(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd0, 5'd9);
    check("pend9_kept", {63'd0, oitf_alloc_ready}, 64'd0);
    idle(5'd0, 5'd9);
    check("haz9_pend", {63'd0, dec_src2_hazard}, 64'd1);
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd7, 5'd9);

    // x0 alloc never becomes pending.
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
    check("x0_haz", {63'd0, dec_src1_hazard}, 64'd0);
    check("x0_alloc_ready", {63'd0, oitf_alloc_ready}, 64'd1);

    // Write to idx 6, then reset with pending={7,9} and wen=1.
    step(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd6);
`ifdef WBCK_BYPASS_EN
    check("byp6_sel", {63'd0, dec_src2_byp_sel}, 64'd1);
    check("byp6_dat", {32'd0, dec_src2_byp_dat}, 64'h66);
    check("byp6_haz", {63'd0, dec_src2_hazard}, 64'd0);
`else
    check("wr6_haz", {63'd0, dec_src2_hazard}, 64'd1);
`endif
    rst_n = 1'b0;
    step(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, '0, 1'b1, 5'd11, 5'd7, 5'd9);
    rst_n = 1'b1;
    check("rst2_wen", {63'd0, wbck_dest_wen}, 64'd0);
    check("rst2_haz1", {63'd0, dec_src1_hazard}, 64'd0);
    check("rst2_haz2", {63'd0, dec_src2_hazard}, 64'd0);
    check("rst2_alloc11", {63'd0, oitf_alloc_ready}, 64'd1);

    // Random traffic; ALU never targets a pending rd.
    for (int i = 0; i < 300; i++) begin
      logic [4:0] ai;
      ai = 5'($urandom_range(0, 31));
      if (m_pend[ai]) ai = 5'd0;
      step(1'($urandom_range(0, 1)), ai, $urandom,
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
